msx_reload_sequencer: RTL and testbench
=======================================

// Module: msx_reload_sequencer
// PURPOSE
//  Sequences a cold restart of the MSX core after a slot/mapper/SRAM config change or a user reset.
//  Waits for the config word to settle, flushes dirty SRAM, holds the core in reset and requests ROM loads per slot, then releases.
//  Sits between the config decoder (cfg_word/reload) and the reset/ROM-loader logic in the top level.
// PARAMETERS
//  SETTLE_CYC   1024  cycles cfg_word must be unchanged before the sequence proceeds
//  RESET_CYC    64    minimum cycles msx_reset is held asserted
//  ACK_TIMEOUT  2^20  cycles to wait for save_ack/load_ack before aborting that step
//  CFG_W        19    width of cfg_word
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      async active-low reset
//  cfg_word       in   CFG_W  current config word (cart types, mappers, SRAM select)
//  reload         in   1      level: config differs from last applied config
//  user_reset     in   1      pulse: user-requested reset (no config change)
//  sdram_ready    in   1      SDRAM initialised; no request issued while low
//  sram_dirty     in   1      battery SRAM has unsaved writes
//  slot_need_load in   2      per slot [A,B]: slot type requires a ROM image
//  save_ack       in   1      SRAM save complete (1-cycle pulse)
//  load_ack       in   1      ROM load complete for load_slot (1-cycle pulse)
//  msx_reset      out  1      core reset, active-high
//  save_req       out  1      level: request SRAM flush; held until save_ack or timeout
//  load_req       out  1      level: request ROM load; held until load_ack or timeout
//  load_slot      out  1      0=slot A, 1=slot B; valid while load_req
//  busy           out  1      sequence in progress (state != IDLE)
//  reload_done    out  1      1-cycle pulse on return to IDLE
//  timeout_err    out  1      sticky; set on any ACK timeout, cleared at next SETTLE entry
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE; msx_reset=1, other outputs 0, counters 0, slot bits cleared, cfg_snap=cfg_word (sampled on release).
//  First clock after reset_n deasserts: forced entry to SETTLE (power-up = implicit reload).
//  IDLE: reload=1 or user_reset=1 -> SETTLE next cycle. msx_reset=0.
//  SETTLE: latch cfg_snap each cycle; cfg_word != cfg_snap -> counter to 0. Counter==SETTLE_CYC-1 && sdram_ready -> SAVE if sram_dirty else ASSERT. Core keeps running (msx_reset=0).
//  SAVE: save_req=1, msx_reset=0 (core stays live so SRAM is coherent). save_ack -> ASSERT. Timeout -> timeout_err=1, ASSERT.
//  ASSERT: msx_reset=1 from this cycle on; hold RESET_CYC cycles, then -> LOAD_A if slot_need_load[0], else LOAD_B if [1], else RELEASE.
//   slot_need_load is sampled once on ASSERT entry; later changes are ignored until the next sequence.
//  LOAD_A/LOAD_B: load_req=1, load_slot=0/1, msx_reset=1. load_ack -> next slot needing load or RELEASE. Timeout -> timeout_err=1, advance as for ack.
//   load_req deasserts the cycle after load_ack. LOAD_A->LOAD_B inserts one idle cycle with load_req=0 (distinct requests).
//  RELEASE: msx_reset=0, reload_done=1 for one cycle, -> IDLE.
//  Simultaneous events:
//   - reload/user_reset in SAVE..LOAD: remembered in pending flag; after RELEASE go to SETTLE instead of IDLE (reload_done still pulses).
//   - cfg_word change outside SETTLE has the same effect.
//   - save_ack and timeout in the same cycle: ack wins, no error.
//   - Stray ack outside its state: ignored.
//  sdram_ready dropping mid-sequence: current req held, timeout counter keeps running.
//  Timeout counter: clog2(ACK_TIMEOUT) bits, cleared on state entry, never wraps; saturates at compare.
//  Latency, no change pending and no loads:
//   - IDLE->RELEASE = 1+SETTLE_CYC+RESET_CYC cycles.
//   - msx_reset asserted for exactly RESET_CYC cycles.
// STRUCTURE
//  Shared package (MSX): typedef enum reload_state_t {IDLE,SETTLE,SAVE,ASSERT,LOAD_A,LOAD_B,RELEASE}; localparams for default cycle counts.
//  One sub-module: msx_seq_timer (load/clear, count, terminal-count flag).
//   - Instanced once, shared by SETTLE/ASSERT/timeout since the states are mutually exclusive.
//  Main FSM: single always_ff with async reset_n; outputs registered (glitch-free msx_reset).
// TESTING (SETTLE_CYC=16, RESET_CYC=4, ACK_TIMEOUT=32 in bench)
//  1. Release reset_n, sdram_ready=1, no dirty, no loads -> msx_reset low 17 cycles, high 4, reload_done at cycle 22, then IDLE.
//  2. reload=1 with cfg_word toggling every 10 cycles for 50 cycles -> no ASSERT until 16 stable cycles after last change.
//  3. sram_dirty=1, save_ack at +5 -> save_req 5 cycles with msx_reset=0, then 4 reset cycles, reload_done.
//  4. slot_need_load=2'b11, load_ack at +3 each -> load_req slot0 3 cyc, 1 gap cycle, slot1 3 cyc; msx_reset high throughout.
//  5. No load_ack for slot A -> load_req drops after 32 cycles, timeout_err=1, slot B still requested, done pulses.
//  6. user_reset during LOAD_A, then reset_n low mid-LOAD_B -> pending causes SETTLE after RELEASE; async reset forces msx_reset=1 immediately.

Source files
------------

// File: rtl/msx_pkg.sv
// rtl/msx_pkg.sv - shared types and default timings for the MSX reload sequencer
package msx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAVE,
      ASSERT,
      LOAD_A,
      LOAD_B,
      RELEASE
   } reload_state_t;

   localparam int DEF_SETTLE_CYC  = 1024;
   localparam int DEF_RESET_CYC   = 64;
   localparam int DEF_ACK_TIMEOUT = 1 << 20;
   localparam int DEF_CFG_W       = 19;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/msx_seq_timer.sv
// rtl/msx_seq_timer.sv - clearable up-counter that saturates at a run-time limit
module msx_seq_timer #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] count;

   assign tc = (count == limit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (!tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/msx_reload_sequencer.sv
// rtl/msx_reload_sequencer.sv - cold-restart sequencer: settle, SRAM flush, core reset, ROM loads
module msx_reload_sequencer
   import msx_pkg::*;
#(
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int RESET_CYC   = DEF_RESET_CYC,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int CFG_W       = DEF_CFG_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CFG_W-1:0] cfg_word,
   input  logic             reload,
   input  logic             user_reset,
   input  logic             sdram_ready,
   input  logic             sram_dirty,
   input  logic [1:0]       slot_need_load,
   input  logic             save_ack,
   input  logic             load_ack,
   output logic             msx_reset,
   output logic             save_req,
   output logic             load_req,
   output logic             load_slot,
   output logic             busy,
   output logic             reload_done,
   output logic             timeout_err
);

   localparam int TMAX = max3(SETTLE_CYC, RESET_CYC, ACK_TIMEOUT);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] SETTLE_LIM = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] RESET_LIM  = TW'(RESET_CYC - 1);
   localparam logic [TW-1:0] ACK_LIM    = TW'(ACK_TIMEOUT - 1);

   reload_state_t    state, state_d;
   logic [CFG_W-1:0] cfg_snap;
   logic [1:0]       slot_need;
   logic             pending;
   logic             gap, gap_d;
   logic             err_set;
   logic             cfg_change, trigger;
   logic             tmr_clear, tmr_tc;
   logic [TW-1:0]    tmr_limit;

   assign cfg_change = (cfg_word != cfg_snap);
   assign trigger    = reload | user_reset | cfg_change;
   // One timer serves settle, reset-hold and ack timeout; the gap cycle restarts it for slot B.
   assign tmr_clear  = (state_d != state) || ((state == SETTLE) && cfg_change) ||
                       ((state == LOAD_B) && gap);

   msx_seq_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .limit   (tmr_limit),
      .tc      (tmr_tc)
   );

   always_comb begin
      state_d   = state;
      gap_d     = gap;
      err_set   = 1'b0;
      tmr_limit = ACK_LIM;
      case (state)
         IDLE: begin
            if (pending || trigger) state_d = SETTLE;
         end
         SETTLE: begin
            tmr_limit = SETTLE_LIM;
            if (tmr_tc && !cfg_change && sdram_ready)
               state_d = sram_dirty ? SAVE : ASSERT;
         end
         SAVE: begin
            if (save_ack || tmr_tc) begin
               err_set = !save_ack;
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            tmr_limit = RESET_LIM;
            if (tmr_tc) begin
               if (slot_need[0])      state_d = LOAD_A;
               else if (slot_need[1]) state_d = LOAD_B;
               else                   state_d = RELEASE;
            end
         end
         LOAD_A: begin
            if (load_ack || tmr_tc) begin
               err_set = !load_ack;
               if (slot_need[1]) begin
                  state_d = LOAD_B;
                  gap_d   = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         LOAD_B: begin
            if (gap) begin
               gap_d = 1'b0;
            end else if (load_ack || tmr_tc) begin
               err_set = !load_ack;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            state_d = (pending || trigger) ? SETTLE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the current state so msx_reset never glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cfg_snap    <= '0;
         slot_need   <= 2'b00;
         pending     <= 1'b1;
         gap         <= 1'b0;
         timeout_err <= 1'b0;
         msx_reset   <= 1'b1;
         save_req    <= 1'b0;
         load_req    <= 1'b0;
         load_slot   <= 1'b0;
         busy        <= 1'b0;
         reload_done <= 1'b0;
      end else begin
         state <= state_d;
         gap   <= gap_d;
         if (state_d == SETTLE) cfg_snap <= cfg_word;
         if ((state != ASSERT) && (state_d == ASSERT)) slot_need <= slot_need_load;
         if (state_d == SETTLE) pending <= 1'b0;
         else if ((state != IDLE) && (state != SETTLE) && trigger) pending <= 1'b1;
         if ((state != SETTLE) && (state_d == SETTLE)) timeout_err <= 1'b0;
         else if (err_set) timeout_err <= 1'b1;
         msx_reset   <= (state == ASSERT) || (state == LOAD_A) || (state == LOAD_B);
         save_req    <= (state == SAVE);
         load_req    <= (state == LOAD_A) || ((state == LOAD_B) && !gap);
         load_slot   <= (state == LOAD_B);
         busy        <= (state != IDLE);
         reload_done <= (state == RELEASE);
      end
   end

endmodule

// File: tb/tb_msx_reload_sequencer.sv
// tb/tb_msx_reload_sequencer.sv - directed self-checking bench for msx_reload_sequencer
module tb_msx_reload_sequencer;

   localparam int SETTLE_CYC  = 16;
   localparam int RESET_CYC   = 4;
   localparam int ACK_TIMEOUT = 32;
   localparam int CFG_W       = 19;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [CFG_W-1:0] cfg_word;
   logic             reload, user_reset, sdram_ready, sram_dirty;
   logic [1:0]       slot_need_load;
   logic             save_ack, load_ack;
   logic             msx_reset, save_req, load_req, load_slot, busy, reload_done, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   int n_mr, first_mr, mr_after_done, n_done, first_done, busy_after;
   int n_sr, n_la, n_lb, last_la, first_lb, mr_on_save, mr_low_on_req;

   always #5 clk = ~clk;

   msx_reload_sequencer #(
      .SETTLE_CYC  (SETTLE_CYC),
      .RESET_CYC   (RESET_CYC),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CFG_W       (CFG_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_word       (cfg_word),
      .reload         (reload),
      .user_reset     (user_reset),
      .sdram_ready    (sdram_ready),
      .sram_dirty     (sram_dirty),
      .slot_need_load (slot_need_load),
      .save_ack       (save_ack),
      .load_ack       (load_ack),
      .msx_reset      (msx_reset),
      .save_req       (save_req),
      .load_req       (load_req),
      .load_slot      (load_slot),
      .busy           (busy),
      .reload_done    (reload_done),
      .timeout_err    (timeout_err)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Sample index 0 is the negedge the trigger is applied on; sample k follows posedge k.
   // sack/lack_*: the ack is captured on the N-th clock of the request (0 = never).
   task automatic run(input int trig, input int n, input int sack, input int lack_a,
                      input int lack_b, input bit toggle, input bit ur_in_la, input bit drop_need);
      int sr_cnt, la_cnt, lb_cnt;
      logic la, lb;
      sr_cnt = 0; la_cnt = 0; lb_cnt = 0;
      n_mr = 0; first_mr = -1; mr_after_done = -1; n_done = 0; first_done = -1; busy_after = -1;
      n_sr = 0; n_la = 0; n_lb = 0; last_la = -1; first_lb = -1; mr_on_save = 0; mr_low_on_req = 0;
      if (trig == 1) reload = 1'b1;
      if (trig == 2) user_reset = 1'b1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         reload = 1'b0; user_reset = 1'b0; save_ack = 1'b0; load_ack = 1'b0;
         la = load_req && !load_slot;
         lb = load_req && load_slot;
         if (msx_reset) begin
            n_mr++;
            if (first_mr < 0) first_mr = k;
            if (first_done >= 0 && mr_after_done < 0) mr_after_done = k;
         end
         if (first_done >= 0 && k == first_done + 1) busy_after = busy;
         if (reload_done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
         if (save_req) begin sr_cnt++; n_sr++; if (msx_reset) mr_on_save++; end
         if (la) begin la_cnt++; n_la++; last_la = k; end
         if (lb) begin lb_cnt++; n_lb++; if (first_lb < 0) first_lb = k; end
         if ((la || lb) && !msx_reset) mr_low_on_req++;
         if (save_req && sr_cnt == sack - 1) save_ack = 1'b1;
         if (la && la_cnt == lack_a - 1) load_ack = 1'b1;
         if (lb && lb_cnt == lack_b - 1) load_ack = 1'b1;
         if (ur_in_la && la && la_cnt == 1) user_reset = 1'b1;
         if (toggle && (k % 10 == 0) && k <= 50) cfg_word = cfg_word ^ 19'h2A5A5;
         if (drop_need && k == 19) slot_need_load = 2'b00;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset_n = 1'b0; reload = 1'b0; user_reset = 1'b0; sdram_ready = 1'b1; sram_dirty = 1'b0;
      slot_need_load = 2'b00; save_ack = 1'b0; load_ack = 1'b0; cfg_word = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_msx_reset", msx_reset, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_save_req", save_req, 0);
      check_eq("rst_load_req", load_req, 0);
      check_eq("rst_reload_done", reload_done, 0);
      check_eq("rst_timeout_err", timeout_err, 0);

      // 1: power-up acts as an implicit reload
      reset_n = 1'b1;
      run(0, 30, 0, 0, 0, 0, 0, 0);
      check_eq("t1_first_mr", first_mr, 18);
      check_eq("t1_mr_cycles", n_mr, RESET_CYC);
      check_eq("t1_done_at", first_done, 22);
      check_eq("t1_done_count", n_done, 1);
      check_eq("t1_idle_after", busy_after, 0);

      // 2: cfg_word keeps changing while settling
      run(1, 80, 0, 0, 0, 1, 0, 0);
      check_eq("t2_first_mr", first_mr, 68);
      check_eq("t2_done_at", first_done, 72);
      check_eq("t2_mr_cycles", n_mr, RESET_CYC);

      // 3: dirty SRAM flush acked on its 5th cycle, triggered by user_reset
      sram_dirty = 1'b1;
      run(2, 40, 5, 0, 0, 0, 0, 0);
      check_eq("t3_save_cycles", n_sr, 5);
      check_eq("t3_mr_during_save", mr_on_save, 0);
      check_eq("t3_mr_cycles", n_mr, RESET_CYC);
      check_eq("t3_done_at", first_done, 27);

      // 3b: save_ack coincides with the timeout -> ack wins
      run(1, 70, ACK_TIMEOUT, 0, 0, 0, 0, 0);
      check_eq("t3b_save_cycles", n_sr, ACK_TIMEOUT);
      check_eq("t3b_timeout_err", timeout_err, 0);
      check_eq("t3b_done_at", first_done, 54);
      sram_dirty = 1'b0;

      // 4: both slots load; slot_need_load changed mid-ASSERT must be ignored
      slot_need_load = 2'b11;
      run(1, 40, 0, 3, 3, 0, 0, 1);
      check_eq("t4_slot_a_cycles", n_la, 3);
      check_eq("t4_slot_b_cycles", n_lb, 3);
      check_eq("t4_gap", first_lb - last_la, 2);
      check_eq("t4_mr_cycles", n_mr, 11);
      check_eq("t4_mr_low_on_req", mr_low_on_req, 0);
      check_eq("t4_done_at", first_done, 29);

      // 5: slot A never acks
      slot_need_load = 2'b11;
      run(1, 70, 0, 0, 3, 0, 0, 0);
      check_eq("t5_slot_a_cycles", n_la, ACK_TIMEOUT);
      check_eq("t5_slot_b_cycles", n_lb, 3);
      check_eq("t5_timeout_err", timeout_err, 1);
      check_eq("t5_done_count", n_done, 1);
      check_eq("t5_done_at", first_done, 58);

      // 6a: user_reset during LOAD_A re-enters SETTLE after RELEASE
      run(1, 60, 0, 3, 3, 0, 1, 0);
      check_eq("t6_done_at", first_done, 29);
      check_eq("t6_busy_after_done", busy_after, 1);
      check_eq("t6_next_mr", mr_after_done, 46);
      check_eq("t6_err_cleared", timeout_err, 0);

      // 6b: async reset in the middle of LOAD_B
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (load_req && load_slot) found = 1'b1;
      end
      check_eq("t6_reach_load_b", found, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("t6_async_msx_reset", msx_reset, 1);
      check_eq("t6_async_load_req", load_req, 0);
      check_eq("t6_async_busy", busy, 0);
      check_eq("t6_async_err", timeout_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
